// File: rtl/clint_ctrl_pkg.sv
// Shared core CSR addresses, trap cause codes and mstatus bit positions.
// Imported by the interrupt sequencer and by anything that decodes its CSR writes.
package clint_ctrl_pkg;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;

  localparam logic [31:0] CAUSE_ECALL  = 32'd11;
  localparam logic [31:0] CAUSE_EBREAK = 32'd3;
  localparam logic [31:0] CAUSE_TIMER  = 32'h8000_0007;

  localparam int MSTATUS_MIE_BIT  = 3;
  localparam int MSTATUS_MPIE_BIT = 7;

  typedef struct packed {
    logic [11:0] addr;
    logic [31:0] data;
  } csr_wr_t;

endpackage

// File: rtl/clint_ctrl_if.sv
// Sequencer-to-core bundle: dedicated CSR write port plus pipeline hold and PC redirect.
// The sequencer drives it as master; the CSR file and fetch stage consume it as slave.
interface clint_ctrl_if #(
  parameter int CPU_WIDTH      = 32,
  parameter int CSR_ADDR_WIDTH = 12
);
  logic                      clint_csr_wr_en;
  logic [CSR_ADDR_WIDTH-1:0] clint_csr_wr_adder;
  logic [CPU_WIDTH-1:0]      clint_csr_wr_data;
  logic                      hold_flag;
  logic                      int_assert;
  logic [CPU_WIDTH-1:0]      int_addr;

  modport master (
    output clint_csr_wr_en, clint_csr_wr_adder, clint_csr_wr_data,
    output hold_flag, int_assert, int_addr
  );

  modport slave (
    input clint_csr_wr_en, clint_csr_wr_adder, clint_csr_wr_data,
    input hold_flag, int_assert, int_addr
  );
endinterface

// File: rtl/clint_ctrl.sv
// Core-local trap sequencer: stalls the pipeline, writes mepc/mstatus/mcause one per
// cycle through the clint CSR port, then pulses a PC redirect to mtvec or mepc.
module clint_ctrl
  import clint_ctrl_pkg::*;
#(
  parameter int CPU_WIDTH      = 32,
  parameter int CSR_ADDR_WIDTH = 12
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 inst_ecall_i,
  input  logic                 inst_ebreak_i,
  input  logic                 inst_mret_i,
  input  logic [CPU_WIDTH-1:0] inst_addr_i,
  input  logic                 inst_valid_i,
  input  logic                 irq_timer_i,
  input  logic [CPU_WIDTH-1:0] csr_mtvec_i,
  input  logic [CPU_WIDTH-1:0] csr_mepc_i,
  input  logic [CPU_WIDTH-1:0] csr_mstatus_i,
  clint_ctrl_if.master         bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_WR_MEPC, S_WR_MSTATUS, S_WR_MCAUSE, S_ASSERT, S_MRET_MSTATUS, S_MRET_ASSERT
  } state_e;

  state_e                    state_q, state_d;
  logic [CPU_WIDTH-1:0]      cause_q, cause_d;
  logic [CPU_WIDTH-1:0]      epc_q, epc_d;
  logic                      accept;
  logic                      wr_en;
  logic [CSR_ADDR_WIDTH-1:0] wr_addr;
  logic [CPU_WIDTH-1:0]      wr_data;
  logic                      redirect;
  logic [CPU_WIDTH-1:0]      redirect_addr;
  logic [CPU_WIDTH-1:0]      mstatus_trap;
  logic [CPU_WIDTH-1:0]      mstatus_mret;

  // Trap entry stacks MIE into MPIE and disables; mret restores MIE and sets MPIE.
  always_comb begin
    mstatus_trap                   = csr_mstatus_i;
    mstatus_trap[MSTATUS_MPIE_BIT] = csr_mstatus_i[MSTATUS_MIE_BIT];
    mstatus_trap[MSTATUS_MIE_BIT]  = 1'b0;
    mstatus_mret                   = csr_mstatus_i;
    mstatus_mret[MSTATUS_MIE_BIT]  = csr_mstatus_i[MSTATUS_MPIE_BIT];
    mstatus_mret[MSTATUS_MPIE_BIT] = 1'b1;
  end

  always_comb begin
    state_d       = state_q;
    cause_d       = cause_q;
    epc_d         = epc_q;
    accept        = 1'b0;
    wr_en         = 1'b0;
    wr_addr       = '0;
    wr_data       = '0;
    redirect      = 1'b0;
    redirect_addr = '0;
    if (!rst) begin
      unique case (state_q)
        S_IDLE: begin
          if (inst_valid_i && inst_ecall_i) begin
            accept  = 1'b1;
            cause_d = CPU_WIDTH'(CAUSE_ECALL);
            epc_d   = inst_addr_i;
            state_d = S_WR_MEPC;
          end else if (inst_valid_i && inst_ebreak_i) begin
            accept  = 1'b1;
            cause_d = CPU_WIDTH'(CAUSE_EBREAK);
            epc_d   = inst_addr_i;
            state_d = S_WR_MEPC;
          end else if (inst_valid_i && inst_mret_i) begin
            accept  = 1'b1;
            epc_d   = inst_addr_i;
            state_d = S_MRET_MSTATUS;
          end else if (irq_timer_i && csr_mstatus_i[MSTATUS_MIE_BIT]) begin
            accept  = 1'b1;
            cause_d = CPU_WIDTH'(CAUSE_TIMER);
            epc_d   = inst_addr_i;
            state_d = S_WR_MEPC;
          end
        end
        S_WR_MEPC: begin
          wr_en   = 1'b1;
          wr_addr = CSR_ADDR_WIDTH'(CSR_MEPC);
          wr_data = epc_q;
          state_d = S_WR_MSTATUS;
        end
        S_WR_MSTATUS: begin
          wr_en   = 1'b1;
          wr_addr = CSR_ADDR_WIDTH'(CSR_MSTATUS);
          wr_data = mstatus_trap;
          state_d = S_WR_MCAUSE;
        end
        S_WR_MCAUSE: begin
          wr_en   = 1'b1;
          wr_addr = CSR_ADDR_WIDTH'(CSR_MCAUSE);
          wr_data = cause_q;
          state_d = S_ASSERT;
        end
        S_ASSERT: begin
          redirect      = 1'b1;
          redirect_addr = csr_mtvec_i;
          state_d       = S_IDLE;
        end
        S_MRET_MSTATUS: begin
          wr_en   = 1'b1;
          wr_addr = CSR_ADDR_WIDTH'(CSR_MSTATUS);
          wr_data = mstatus_mret;
          state_d = S_MRET_ASSERT;
        end
        S_MRET_ASSERT: begin
          redirect      = 1'b1;
          redirect_addr = csr_mepc_i;
          state_d       = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cause_q <= '0;
      epc_q   <= '0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      epc_q   <= epc_d;
    end
  end

  // Hold is combinational so the trapping instruction is flushed in its own cycle.
  assign bus.hold_flag          = !rst && ((state_q != S_IDLE) || accept);
  assign bus.clint_csr_wr_en    = wr_en;
  assign bus.clint_csr_wr_adder = wr_addr;
  assign bus.clint_csr_wr_data  = wr_data;
  assign bus.int_assert         = redirect;
  assign bus.int_addr           = redirect_addr;

endmodule

// File: tb/tb_clint_ctrl.sv
// Directed bench for clint_ctrl: expected CSR writes and redirects are queued as each
// event is driven and popped by a negedge monitor as the sequencer emits them.
module tb_clint_ctrl;
  import clint_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_ecall, inst_ebreak, inst_mret, inst_valid, irq_timer;
  logic [31:0] inst_addr, csr_mtvec, csr_mepc, csr_mstatus;

  int checks = 0;
  int errors = 0;
  int redirect_pulses = 0;

  csr_wr_t     wr_q[$];
  logic [31:0] redir_q[$];

  clint_ctrl_if #(.CPU_WIDTH(32), .CSR_ADDR_WIDTH(12)) bus ();

  clint_ctrl #(.CPU_WIDTH(32), .CSR_ADDR_WIDTH(12)) dut (
    .clk           (clk),
    .rst           (rst),
    .inst_ecall_i  (inst_ecall),
    .inst_ebreak_i (inst_ebreak),
    .inst_mret_i   (inst_mret),
    .inst_addr_i   (inst_addr),
    .inst_valid_i  (inst_valid),
    .irq_timer_i   (irq_timer),
    .csr_mtvec_i   (csr_mtvec),
    .csr_mepc_i    (csr_mepc),
    .csr_mstatus_i (csr_mstatus),
    .bus           (bus.master)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Check hold on each of n cycles, starting with the current one.
  task automatic hold_for(input int n, input logic exp, input string tag);
    for (int i = 0; i < n; i++) begin
      if (i != 0) tick();
      #1 chk(tag, {31'd0, bus.hold_flag}, {31'd0, exp});
    end
  endtask

  task automatic push_trap(input logic [31:0] epc, input logic [31:0] mst,
                           input logic [31:0] cause, input logic [31:0] mtvec);
    logic [31:0] m;
    m      = mst;
    m[7]   = mst[3];
    m[3]   = 1'b0;
    wr_q.push_back('{addr: CSR_MEPC,    data: epc});
    wr_q.push_back('{addr: CSR_MSTATUS, data: m});
    wr_q.push_back('{addr: CSR_MCAUSE,  data: cause});
    redir_q.push_back(mtvec);
  endtask

  // Monitor: every write / redirect must match the head of its queue; idle buses must be zero.
  always @(negedge clk) begin
    if (bus.clint_csr_wr_en) begin
      if (wr_q.size() == 0) begin
        chk("unexpected_csr_write", {20'd0, bus.clint_csr_wr_adder}, 32'hFFFF_FFFF);
      end else begin
        csr_wr_t e;
        e = wr_q.pop_front();
        chk("csr_wr_addr", {20'd0, bus.clint_csr_wr_adder}, {20'd0, e.addr});
        chk("csr_wr_data", bus.clint_csr_wr_data, e.data);
      end
    end else begin
      chk("idle_wr_addr_data", bus.clint_csr_wr_data | {20'd0, bus.clint_csr_wr_adder}, 32'd0);
    end
    if (bus.int_assert) begin
      redirect_pulses++;
      if (redir_q.size() == 0) chk("unexpected_redirect", bus.int_addr, 32'hFFFF_FFFF);
      else chk("redirect_addr", bus.int_addr, redir_q.pop_front());
    end else begin
      chk("idle_int_addr", bus.int_addr, 32'd0);
    end
  end

  initial begin
    rst = 1'b1; inst_ecall = 0; inst_ebreak = 0; inst_mret = 0; inst_valid = 0;
    irq_timer = 0; inst_addr = 0; csr_mtvec = 32'h80; csr_mepc = 0; csr_mstatus = 0;
    tick(); tick();
    #1 chk("reset_hold", {31'd0, bus.hold_flag}, 32'd0);
    chk("reset_wr_en", {31'd0, bus.clint_csr_wr_en}, 32'd0);
    chk("reset_int_assert", {31'd0, bus.int_assert}, 32'd0);
    rst = 1'b0;
    tick();

    // ecall at 0x100 with MIE set
    csr_mstatus = 32'h8; inst_addr = 32'h100; inst_valid = 1; inst_ecall = 1;
    push_trap(32'h100, 32'h8, 32'd11, 32'h80);
    hold_for(1, 1'b1, "ecall_hold_T");
    tick(); inst_valid = 0; inst_ecall = 0;
    hold_for(4, 1'b1, "ecall_hold_seq");
    tick(); hold_for(1, 1'b0, "ecall_hold_T5");

    // mret restoring MIE from MPIE
    csr_mstatus = 32'h80; csr_mepc = 32'h104; inst_addr = 32'h104; inst_valid = 1; inst_mret = 1;
    wr_q.push_back('{addr: CSR_MSTATUS, data: 32'h88});
    redir_q.push_back(32'h104);
    hold_for(1, 1'b1, "mret_hold_T");
    tick(); inst_valid = 0; inst_mret = 0;
    hold_for(2, 1'b1, "mret_hold_seq");
    tick(); hold_for(1, 1'b0, "mret_hold_after");

    // timer masked by MIE=0, then taken once MIE=1
    csr_mstatus = 32'h0; irq_timer = 1;
    hold_for(10, 1'b0, "timer_masked");
    tick(); csr_mstatus = 32'h8; inst_addr = 32'h200;
    push_trap(32'h200, 32'h8, 32'h8000_0007, 32'h80);
    hold_for(1, 1'b1, "timer_hold_T");
    tick(); hold_for(4, 1'b1, "timer_hold_seq");
    csr_mstatus = 32'h80;
    tick(); hold_for(3, 1'b0, "timer_no_reentry");

    // ecall and timer together: ecall wins; irq stays high but MIE is now clear
    csr_mstatus = 32'h8; inst_addr = 32'h300; inst_valid = 1; inst_ecall = 1;
    push_trap(32'h300, 32'h8, 32'd11, 32'h80);
    hold_for(1, 1'b1, "prio_hold_T");
    tick(); inst_valid = 0; inst_ecall = 0;
    hold_for(4, 1'b1, "prio_hold_seq");
    csr_mstatus = 32'h80;
    tick(); hold_for(5, 1'b0, "prio_no_second_trap");
    irq_timer = 0;

    // ebreak arriving mid-sequence is ignored
    csr_mstatus = 32'h8; inst_addr = 32'h400; inst_valid = 1; inst_ecall = 1;
    push_trap(32'h400, 32'h8, 32'd11, 32'h80);
    tick(); inst_ecall = 0; inst_valid = 0;
    tick(); inst_ebreak = 1; inst_valid = 1; inst_addr = 32'h404;
    hold_for(1, 1'b1, "ebreak_ignored_hold");
    tick(); inst_ebreak = 0; inst_valid = 0;
    tick(); tick(); hold_for(2, 1'b0, "ebreak_ignored_after");
    chk("redirect_pulse_count", redirect_pulses, 5);

    // reset in WR_MSTATUS aborts the sequence
    inst_addr = 32'h500; inst_valid = 1; inst_ecall = 1;
    wr_q.push_back('{addr: CSR_MEPC, data: 32'h500});
    tick(); inst_ecall = 0; inst_valid = 0;
    tick(); rst = 1'b1;
    #1 chk("rst_mid_hold", {31'd0, bus.hold_flag}, 32'd0);
    tick(); rst = 1'b0;
    #1 chk("rst_after_wr_en", {31'd0, bus.clint_csr_wr_en}, 32'd0);
    chk("rst_after_int_assert", {31'd0, bus.int_assert}, 32'd0);
    hold_for(5, 1'b0, "rst_after_hold");

    tick();
    chk("csr_queue_drained", wr_q.size(), 0);
    chk("redirect_queue_drained", redir_q.size(), 0);
    chk("redirect_pulse_total", redirect_pulses, 5);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
